// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional trailing checksum: define LOADER_CHECKSUM_EN.
package loader_pkg;

    // FSM states; ST_CHECK is only reachable with LOADER_CHECKSUM_EN defined
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_CHECK
    } loader_state_t;

    // Default start-of-frame marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Header bytes ahead of the payload: SYNC, LEN_LO, LEN_HI
    localparam int HDR_LEN = 3;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input handshake, instruction-memory write bus and loader status.
// master = loader side, slave = byte source / memory / pipeline side.
interface instr_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, words_loaded
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// 4-byte little-endian lane register: byte k of a word lands in bits [8k+7:8k].
// o_word_valid pulses the cycle after the 4th byte, when o_word is complete.
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last,
    output logic        o_word_valid
);
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic        r_word_valid;

    // 4th byte of the word is being accepted this cycle
    assign o_last       = i_en && (r_idx == 2'd3);
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

    // Lane write, byte index and completed-word pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_idx        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clr) begin
                r_idx <= '0;
            end else if (i_en) begin
                r_word[r_idx*8 +: 8] <= i_byte;
                r_idx                <= r_idx + 2'd1;
                r_word_valid         <= (r_idx == 2'd3);
            end
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Program loader: frames SYNC, LEN_LO, LEN_HI, N*4 data bytes into
// sequential instruction-memory writes starting at BASE_ADDR, stalling the
// CPU while loading. Optional trailing checksum byte: LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int               ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    instr_loader_if.master bus
);
    // Largest word count that still fits above BASE_ADDR
    localparam logic [16:0] LEN_LIMIT = 17'((1 << ADDR_W) - int'(BASE_ADDR));

    loader_state_t     r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic              w_ready;
    logic              w_acc;
    logic [15:0]       w_n;
    logic              w_too_long;
    logic              w_last_word;
    logic              w_start;
    logic [31:0]       w_word;
    logic              w_byte_last;
    logic              w_word_valid;

    // No byte may be taken while the word is written or the frame closes
    assign w_ready     = (r_state != ST_WRITE) && (r_state != ST_DONE);
    assign w_acc       = bus.in_valid && w_ready;
    assign w_n         = {bus.in_data, r_len_lo};
    assign w_too_long  = {1'b0, w_n} > LEN_LIMIT;
    assign w_last_word = (17'(r_words) + 17'd1) == {1'b0, r_len};
    assign w_start     = (r_state == ST_IDLE) && w_acc && (bus.in_data == SYNC_BYTE);

    byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst),
        .i_clr        (w_start),
        .i_en         (w_acc && (r_state == ST_DATA)),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_last       (w_byte_last),
        .o_word_valid (w_word_valid)
    );

    assign bus.in_ready     = w_ready;
    assign bus.mem_we       = w_word_valid;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = w_word;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of length and data bytes of the current frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE) begin
            r_csum <= '0;
        end else if (w_acc && (r_state == ST_LEN_LO || r_state == ST_LEN_HI ||
                               r_state == ST_DATA)) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end
`endif

    // Frame FSM with registered status outputs and write address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_words    <= '0;
            r_mem_addr <= BASE_ADDR;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_LEN_LO;
                        r_cpu_hold <= 1'b1;
                        r_error    <= 1'b0;
                        r_words    <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_acc) begin
                        r_len_lo <= bus.in_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_acc) begin
                        r_len <= w_n;
                        if (w_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state    <= ST_CHECK;
`else
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end else if (w_too_long) begin
                            r_state    <= ST_IDLE;
                            r_error    <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_last) begin
                        r_state    <= ST_WRITE;
                        r_mem_addr <= BASE_ADDR + r_words[ADDR_W-1:0];
                    end
                end
                ST_WRITE: begin
                    r_words <= r_words + (ADDR_W+1)'(1);
                    if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= ST_CHECK;
`else
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_acc) begin
                        r_cpu_hold <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
